sprite_motion_ctrl: RTL and testbench

Per-frame motion scheduler and renderer for several bouncing squares on the 640x480 VGA display. Sits between the VGA controller (x, y, video_on) and the 1-bit-per-channel VGA color outputs. Once per frame it steps through a register file of sprites one per clock, advancing each position and bouncing it off the display edges. Every clock it resolves which sprite, if any, owns the current pixel, using fixed priority.

---
 rtl/sprite_pkg.sv | 36 +++
 rtl/sprite_step.sv | 36 +++
 rtl/sprite_motion_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared FSM states, color table, start positions and frame-tick constants
package sprite_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [9:0] TICK_Y = 10'd481;
   localparam logic [9:0] TICK_X = 10'd0;
   localparam int         IDX_W  = 3;

   localparam logic [2:0] COLOR_BLUE  = 3'b001;
   localparam logic [2:0] COLOR_BLACK = 3'b000;

   // {r,g,b} per sprite index; anything past the named colors renders white
   function automatic logic [2:0] sprite_color(input int idx);
      case (idx)
         0:       return 3'b110;
         1:       return 3'b100;
         2:       return 3'b010;
         3:       return 3'b101;
         default: return 3'b111;
      endcase
   endfunction

   function automatic logic [9:0] init_pos_x(input int idx);
      return 10'(idx * 128);
   endfunction

   function automatic logic [9:0] init_pos_y(input int idx);
      return 10'(idx * 96);
   endfunction

endpackage

// File: rtl/sprite_step.sv
// rtl/sprite_step.sv - one-axis position step with bounce off 0 and the far border
module sprite_step (
   input  logic [9:0] pos,
   input  logic       dir,
   input  logic [9:0] limit,
   input  logic [9:0] size,
   input  logic [9:0] velocity,
   output logic [9:0] pos_nxt,
   output logic       dir_nxt
);

   logic [10:0] far_edge;

   assign far_edge = {1'b0, pos} + {1'b0, velocity} + {1'b0, size} - 11'd1;

   always_comb begin
      pos_nxt = pos;
      dir_nxt = dir;
      if (dir) begin
         if (far_edge > {1'b0, limit}) begin
            pos_nxt = limit - size + 10'd1;
            dir_nxt = 1'b0;
         end else begin
            pos_nxt = pos + velocity;
         end
      end else begin
         if (pos < velocity) begin
            pos_nxt = '0;
            dir_nxt = 1'b1;
         end else begin
            pos_nxt = pos - velocity;
         end
      end
   end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// rtl/sprite_motion_ctrl.sv - per-frame bouncing-square scheduler and fixed-priority renderer
// MOTION_PAUSE_EN adds a pause input that suppresses frame ticks while idle.
module sprite_motion_ctrl
   import sprite_pkg::*;
#(
   parameter int NUM_SPRITES = 4,
   parameter int SQUARE_SIZE = 32,
   parameter int VELOCITY    = 2,
   parameter int X_MAX       = 639,
   parameter int Y_MAX       = 479
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       video_on,
   input  logic [9:0] x,
   input  logic [9:0] y,
`ifdef MOTION_PAUSE_EN
   input  logic       pause,
`endif
   output logic       r,
   output logic       g,
   output logic       b,
   output logic       busy,
   output logic       frame_done
);

   localparam logic [9:0]       SIZE10   = 10'(SQUARE_SIZE);
   localparam logic [10:0]      SIZE11   = 11'(SQUARE_SIZE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   cond_q, cond_d;
   logic                   frame_done_q, frame_done_d;
   logic [2:0]             rgb_q, rgb_d;
   logic [9:0]             pos_x_q [NUM_SPRITES];
   logic [9:0]             pos_x_d [NUM_SPRITES];
   logic [9:0]             pos_y_q [NUM_SPRITES];
   logic [9:0]             pos_y_d [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] dir_x_q, dir_x_d;
   logic [NUM_SPRITES-1:0] dir_y_q, dir_y_d;

   logic       tick, start;
   logic [9:0] sel_x, sel_y, nxt_x, nxt_y;
   logic       sel_dx, sel_dy, nxt_dx, nxt_dy;

   always_comb begin
      sel_x  = '0;
      sel_y  = '0;
      sel_dx = 1'b0;
      sel_dy = 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_x  = pos_x_q[i];
            sel_y  = pos_y_q[i];
            sel_dx = dir_x_q[i];
            sel_dy = dir_y_q[i];
         end
      end
   end

   sprite_step u_step_x (
      .pos      (sel_x),
      .dir      (sel_dx),
      .limit    (10'(X_MAX)),
      .size     (SIZE10),
      .velocity (10'(VELOCITY)),
      .pos_nxt  (nxt_x),
      .dir_nxt  (nxt_dx)
   );

   sprite_step u_step_y (
      .pos      (sel_y),
      .dir      (sel_dy),
      .limit    (10'(Y_MAX)),
      .size     (SIZE10),
      .velocity (10'(VELOCITY)),
      .pos_nxt  (nxt_y),
      .dir_nxt  (nxt_dy)
   );

   // Edge-detect the blanking marker so a held (481,0) yields one tick per frame
   always_comb begin
      cond_d = (y == TICK_Y) && (x == TICK_X);
      tick   = cond_d & ~cond_q;
`ifdef MOTION_PAUSE_EN
      start  = tick & ~pause;
`else
      start  = tick;
`endif
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      dir_x_d = dir_x_q;
      dir_y_d = dir_y_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = UPDATE;
               idx_d   = '0;
            end
         end
         UPDATE: begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  pos_x_d[i] = nxt_x;
                  pos_y_d[i] = nxt_y;
                  dir_x_d[i] = nxt_dx;
                  dir_y_d[i] = nxt_dy;
               end
            end
            if (idx_q == LAST_IDX) state_d = DONE;
            else                   idx_d   = idx_q + 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      frame_done_d = (state_d == DONE);
   end

   // Walk from highest index down so the lowest hitting sprite wins
   always_comb begin
      rgb_d = COLOR_BLUE;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if ({1'b0, x} >= {1'b0, pos_x_q[i]} && {1'b0, x} <= {1'b0, pos_x_q[i]} + SIZE11 - 11'd1 &&
             {1'b0, y} >= {1'b0, pos_y_q[i]} && {1'b0, y} <= {1'b0, pos_y_q[i]} + SIZE11 - 11'd1)
            rgb_d = sprite_color(i);
      end
      if (!video_on) rgb_d = COLOR_BLACK;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         cond_q       <= 1'b0;
         frame_done_q <= 1'b0;
         rgb_q        <= '0;
         dir_x_q      <= '1;
         dir_y_q      <= '1;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            pos_x_q[i] <= init_pos_x(i);
            pos_y_q[i] <= init_pos_y(i);
         end
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cond_q       <= cond_d;
         frame_done_q <= frame_done_d;
         rgb_q        <= rgb_d;
         pos_x_q      <= pos_x_d;
         pos_y_q      <= pos_y_d;
         dir_x_q      <= dir_x_d;
         dir_y_q      <= dir_y_d;
      end
   end

   assign {r, g, b}  = rgb_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb/tb_sprite_motion_ctrl.sv - scoreboard bench for sprite_motion_ctrl (optionally MOTION_PAUSE_EN)
module tb_sprite_motion_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       video_on;
   logic [9:0] x, y;
`ifdef MOTION_PAUSE_EN
   logic       pause;
`endif
   logic ra, ga, ba, busy_a, fd_a;
   logic rb, gb, bb, busy_b, fd_b;

   always #5 clk = ~clk;

   sprite_motion_ctrl dut_a (
      .clk(clk), .reset(reset), .video_on(video_on), .x(x), .y(y),
`ifdef MOTION_PAUSE_EN
      .pause(pause),
`endif
      .r(ra), .g(ga), .b(ba), .busy(busy_a), .frame_done(fd_a)
   );

   sprite_motion_ctrl #(.NUM_SPRITES(5), .SQUARE_SIZE(160)) dut_b (
      .clk(clk), .reset(reset), .video_on(video_on), .x(x), .y(y),
`ifdef MOTION_PAUSE_EN
      .pause(pause),
`endif
      .r(rb), .g(gb), .b(bb), .busy(busy_b), .frame_done(fd_b)
   );

   typedef struct {
      logic [2:0] exp_a;
      logic [2:0] exp_b;
      string      name;
   } pix_t;

   pix_t exp_q[$];
   pix_t mon_e;
   logic pix_req = 1'b0;
   logic req_d   = 1'b0;
   int   checks   = 0;
   int   errors   = 0;
   int   busy_cnt = 0;
   int   fd_cnt   = 0;

   always @(posedge clk) req_d <= pix_req;

   always @(negedge clk) begin
      if (busy_a) busy_cnt++;
      if (fd_a)   fd_cnt++;
      if (req_d) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow: output presented with no expectation queued");
         end else begin
            mon_e = exp_q.pop_front();
            checks += 2;
            if ({ra, ga, ba} !== mon_e.exp_a) begin
               errors++;
               $display("FAIL %s size32: rgb got %b expected %b", mon_e.name, {ra, ga, ba}, mon_e.exp_a);
            end
            if ({rb, gb, bb} !== mon_e.exp_b) begin
               errors++;
               $display("FAIL %s size160: rgb got %b expected %b", mon_e.name, {rb, gb, bb}, mon_e.exp_b);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic pixel(input int px, input int py, input logic vo,
                        input logic [2:0] ea, input logic [2:0] eb, input string nm);
      x        = 10'(px);
      y        = 10'(py);
      video_on = vo;
      pix_req  = 1'b1;
      exp_q.push_back('{ea, eb, nm});
      step();
      pix_req  = 1'b0;
   endtask

   task automatic do_tick();
      x        = 10'd0;
      y        = 10'd481;
      video_on = 1'b0;
      step();
      y = 10'd0;
      repeat (10) step();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset    = 1'b1;
      video_on = 1'b0;
      x        = '0;
      y        = '0;
`ifdef MOTION_PAUSE_EN
      pause    = 1'b0;
`endif
      repeat (3) step();
      reset = 1'b0;
      step();

      // reset asserted mid-frame while a green pixel is being drawn
      x = 10'd260; y = 10'd200; video_on = 1'b1;
      step(); step();
      #2 reset = 1'b1;
      #1;
      check("reset_rgb_a", int'({ra, ga, ba}), 0);
      check("reset_rgb_b", int'({rb, gb, bb}), 0);
      check("reset_busy", int'(busy_a), 0);
      check("reset_frame_done", int'(fd_a), 0);
      step();
      reset = 1'b0;
      step();

      pixel(0,   0,   1'b1, 3'b110, 3'b110, "pix_0_0");
      pixel(128, 96,  1'b1, 3'b100, 3'b110, "pix_128_96");
      pixel(600, 10,  1'b1, 3'b001, 3'b001, "pix_600_10");
      pixel(31,  31,  1'b1, 3'b110, 3'b110, "pix_31_31");
      pixel(32,  0,   1'b1, 3'b001, 3'b110, "pix_32_0");
      pixel(159, 127, 1'b1, 3'b100, 3'b110, "pix_159_127");
      pixel(160, 127, 1'b1, 3'b001, 3'b100, "pix_160_127");
      pixel(140, 100, 1'b1, 3'b100, 3'b110, "priority_140_100");
      pixel(260, 200, 1'b1, 3'b010, 3'b100, "pix_260_200");
      pixel(400, 300, 1'b1, 3'b101, 3'b010, "pix_400_300");
      pixel(500, 400, 1'b1, 3'b001, 3'b101, "pix_500_400");
      pixel(600, 460, 1'b1, 3'b001, 3'b111, "white_600_460");
      pixel(0,   0,   1'b0, 3'b000, 3'b000, "blank_0_0");
      step();

      // tick marker held for 8 clocks must start exactly one sequence
      busy_cnt = 0;
      fd_cnt   = 0;
      x = 10'd0; y = 10'd481; video_on = 1'b0;
      @(negedge clk);
      check("busy_on_tick_cycle", int'(busy_a), 0);
      @(negedge clk);
      check("busy_after_tick_edge", int'(busy_a), 1);
      repeat (6) step();
      y = 10'd0;
      repeat (10) step();
      check("hold_busy_cycles", busy_cnt, 5);
      check("hold_frame_done_pulses", fd_cnt, 1);
      check("hold_s0_x", int'(dut_a.pos_x_q[0]), 2);
      check("hold_s0_y", int'(dut_a.pos_y_q[0]), 2);
      check("hold_s1_x", int'(dut_a.pos_x_q[1]), 130);
      check("hold_s1_y", int'(dut_a.pos_y_q[1]), 98);

      fd_cnt = 0;
      for (int t = 2; t <= 114; t++) begin
         do_tick();
         if (t == 80)  check("s3_y_tick80", int'(dut_a.pos_y_q[3]), 448);
         if (t == 82)  check("s3_y_tick82", int'(dut_a.pos_y_q[3]), 446);
         if (t == 112) begin
            check("s3_x_tick112", int'(dut_a.pos_x_q[3]), 608);
            check("s3_dirx_tick112", int'(dut_a.dir_x_q[3]), 1);
         end
         if (t == 113) begin
            check("s3_x_tick113", int'(dut_a.pos_x_q[3]), 608);
            check("s3_dirx_tick113", int'(dut_a.dir_x_q[3]), 0);
         end
         if (t == 114) check("s3_x_tick114", int'(dut_a.pos_x_q[3]), 606);
      end
      check("loop_frame_done_pulses", fd_cnt, 113);

      // reset while sprite 2 is being updated
      fd_cnt = 0;
      x = 10'd0; y = 10'd481; video_on = 1'b0;
      begin
         int n = 0;
         while (!(busy_a && dut_a.idx_q == 3'd2) && n < 20) begin
            step();
            n++;
         end
         check("reach_update_idx2_within_budget", int'(n < 20), 1);
      end
      reset = 1'b1;
      step();
      y = 10'd0;
      step();
      reset = 1'b0;
      repeat (8) step();
      check("midupdate_reset_frame_done", fd_cnt, 0);
      check("midupdate_reset_busy", int'(busy_a), 0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("midupdate_reset_s%0d_x", i), int'(dut_a.pos_x_q[i]), i * 128);
         check($sformatf("midupdate_reset_s%0d_y", i), int'(dut_a.pos_y_q[i]), i * 96);
         check($sformatf("midupdate_reset_s%0d_dir", i), int'({dut_a.dir_x_q[i], dut_a.dir_y_q[i]}), 3);
      end
      pixel(0,   0,  1'b1, 3'b110, 3'b110, "post_reset_0_0");
      pixel(128, 96, 1'b1, 3'b100, 3'b110, "post_reset_128_96");
      step();

`ifdef MOTION_PAUSE_EN
      fd_cnt = 0;
      pause  = 1'b1;
      do_tick();
      check("pause_frame_done", fd_cnt, 0);
      check("pause_s0_x", int'(dut_a.pos_x_q[0]), 0);
      check("pause_s1_y", int'(dut_a.pos_y_q[1]), 96);
      pause = 1'b0;
      do_tick();
      check("unpause_frame_done", fd_cnt, 1);
      check("unpause_s0_x", int'(dut_a.pos_x_q[0]), 2);
      check("unpause_s1_y", int'(dut_a.pos_y_q[1]), 98);
`endif

      repeat (2) step();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
